// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/grant/rvalid bus between fetch stage and memory
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// One outstanding imem transaction; stall/flush from hazard unit, redirect from EX.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_if,
   input  logic              flush_if,
   input  logic              pc_src_ex,
   input  logic [31:0]       branch_target_ex,
   if_stage_if.master        imem,
   output logic [31:0]       PC_ID,
   output logic [31:0]       INSTRUCTION_ID,
   output logic              valid_id
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] fetch_pc_q;
   logic [31:0] buf_q;
   logic        kill_q;
   logic [31:0] pc_id_q;
   logic [31:0] instr_id_q;
   logic        valid_id_q;

   logic [31:0] target_d;
   logic        deliver_d;
   logic [31:0] word_d;

   assign target_d = {branch_target_ex[31:2], 2'b00};

   // A word reaches decode only when neither a stall nor a redirect blocks it.
   always_comb begin
      deliver_d = 1'b0;
      word_d    = imem.imem_rdata;
      if (!pc_src_ex && !stall_if) begin
         if (state_q == WAIT && imem.imem_rvalid && !kill_q) begin
            deliver_d = 1'b1;
         end else if (state_q == HOLD) begin
            deliver_d = 1'b1;
            word_d    = buf_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
         buf_q      <= NOP_INSTR;
         kill_q     <= 1'b0;
         pc_id_q    <= 32'h0;
         instr_id_q <= NOP_INSTR;
         valid_id_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: state_q <= REQ;
            REQ: begin
               if (imem.imem_gnt) begin
                  state_q    <= WAIT;
                  fetch_pc_q <= pc_q;
                  kill_q     <= pc_src_ex;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid) begin
                  kill_q <= 1'b0;
                  if (kill_q || pc_src_ex) begin
                     state_q <= REQ;
                  end else if (stall_if) begin
                     buf_q   <= imem.imem_rdata;
                     state_q <= HOLD;
                  end else begin
                     state_q <= REQ;
                  end
               end else if (pc_src_ex) begin
                  kill_q <= 1'b1;
               end
            end
            HOLD: begin
               if (pc_src_ex || !stall_if) state_q <= REQ;
            end
            default: state_q <= IDLE;
         endcase

         // Redirect wins over the sequential increment.
         if (pc_src_ex) begin
            pc_q <= target_d;
         end else if (deliver_d) begin
            pc_q <= fetch_pc_q + 32'd4;
         end

         if (flush_if || pc_src_ex) begin
            pc_id_q    <= 32'h0;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
         end else if (!stall_if) begin
            if (deliver_d) begin
               pc_id_q    <= fetch_pc_q;
               instr_id_q <= word_d;
               valid_id_q <= 1'b1;
            end else begin
               pc_id_q    <= 32'h0;
               instr_id_q <= NOP_INSTR;
               valid_id_q <= 1'b0;
            end
         end
      end
   end

   assign imem.imem_req  = (state_q == REQ);
   assign imem.imem_addr = pc_q;
   assign PC_ID          = pc_id_q;
   assign INSTRUCTION_ID = instr_id_q;
   assign valid_id       = valid_id_q;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage fetch, stall, redirect, wrap and reset
module tb_if_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_if, flush_if, pc_src_ex;
   logic [31:0] branch_target_ex;
   logic [31:0] PC_ID, INSTRUCTION_ID;
   logic        valid_id;

   int checks   = 0;
   int failures = 0;

   logic [31:0] addr_q[$];
   logic [63:0] id_q[$];
   logic        last_stall;
   logic [31:0] mon_addr;
   logic [63:0] mon_id;

   if_stage_if bus();

   if_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall_if         (stall_if),
      .flush_if         (flush_if),
      .pc_src_ex        (pc_src_ex),
      .branch_target_ex (branch_target_ex),
      .imem             (bus),
      .PC_ID            (PC_ID),
      .INSTRUCTION_ID   (INSTRUCTION_ID),
      .valid_id         (valid_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   always @(posedge clk) last_stall <= stall_if;

   // Scoreboard: granted requests against expected addresses, new IF/ID words against expected.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
            checks++;
            if (addr_q.size() == 0) begin
               failures++;
               $display("FAIL sb_addr unexpected grant at addr=%h", bus.imem_addr);
            end else begin
               mon_addr = addr_q.pop_front();
               if (bus.imem_addr !== mon_addr) begin
                  failures++;
                  $display("FAIL sb_addr got=%h exp=%h", bus.imem_addr, mon_addr);
               end
            end
         end
         if (valid_id === 1'b1 && last_stall !== 1'b1) begin
            checks++;
            if (id_q.size() == 0) begin
               failures++;
               $display("FAIL sb_id unexpected pc=%h instr=%h", PC_ID, INSTRUCTION_ID);
            end else begin
               mon_id = id_q.pop_front();
               if ({PC_ID, INSTRUCTION_ID} !== mon_id) begin
                  failures++;
                  $display("FAIL sb_id got=%h/%h exp=%h/%h", PC_ID, INSTRUCTION_ID,
                           mon_id[63:32], mon_id[31:0]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (bus.imem_req !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL req_timeout got=%b exp=1", bus.imem_req);
      end
   endtask

   task automatic fetch_word(input logic [31:0] exp_addr, input logic [31:0] word,
                             input bit deliver);
      wait_req();
      addr_q.push_back(exp_addr);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word;
      if (deliver) id_q.push_back({exp_addr, word});
      tick();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stall_if = 1'b0; flush_if = 1'b0; pc_src_ex = 1'b0; branch_target_ex = 32'h0;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
      tick(); tick();
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
      checks++; if (PC_ID !== 32'h0) begin failures++; $display("FAIL rst_pc_id got=%h exp=0", PC_ID); end
      checks++; if (INSTRUCTION_ID !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", INSTRUCTION_ID, NOP); end
      checks++; if (valid_id !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_id); end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      fetch_word(32'h0, 32'hA000_0001, 1'b1);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin failures++; $display("FAIL seq_b2b got=%b/%h exp=1/4", bus.imem_req, bus.imem_addr); end
      fetch_word(32'h4, 32'hB000_0002, 1'b1);
      fetch_word(32'h8, 32'hC000_0003, 1'b1);
      tick();
      checks++; if (valid_id !== 1'b0 || INSTRUCTION_ID !== NOP) begin failures++; $display("FAIL seq_bubble got=%b/%h exp=0/%h", valid_id, INSTRUCTION_ID, NOP); end
   endtask

   task automatic test_stall();
      fetch_word(32'hC, 32'hD000_0004, 1'b1);
      addr_q.push_back(32'h10);
      bus.imem_gnt = 1'b1;
      stall_if = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.imem_gnt = 1'b0;
         if (i == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hE000_0005;
            id_q.push_back({32'h10, 32'hE000_0005});
         end else begin
            bus.imem_rvalid = 1'b0;
         end
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL stall_noreq cyc=%0d got=%b exp=0", i, bus.imem_req); end
         checks++; if (valid_id !== 1'b1 || PC_ID !== 32'hC || INSTRUCTION_ID !== 32'hD000_0004) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=1/c/d0000004", i, valid_id, PC_ID, INSTRUCTION_ID);
         end
      end
      bus.imem_rvalid = 1'b0;
      stall_if = 1'b0;
      tick();
      checks++; if (valid_id !== 1'b1 || PC_ID !== 32'h10) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/10", valid_id, PC_ID); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/14", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_redirect_wait();
      wait_req();
      addr_q.push_back(32'h14);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      pc_src_ex = 1'b1; branch_target_ex = 32'h103;
      tick();
      pc_src_ex = 1'b0; branch_target_ex = 32'h0;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      bus.imem_rvalid = 1'b0;
      checks++; if (valid_id !== 1'b0) begin failures++; $display("FAIL redir_killed got=%b exp=0", valid_id); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin failures++; $display("FAIL redir_target got=%b/%h exp=1/100", bus.imem_req, bus.imem_addr); end
      pc_src_ex = 1'b1; branch_target_ex = 32'h200;
      tick();
      pc_src_ex = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin failures++; $display("FAIL redir_req got=%b/%h exp=1/200", bus.imem_req, bus.imem_addr); end
      fetch_word(32'h200, 32'h5000_0006, 1'b1);
   endtask

   task automatic test_redirect_hold();
      wait_req();
      addr_q.push_back(32'h204);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hF000_0007;
      stall_if = 1'b1;
      tick();
      bus.imem_rvalid = 1'b0;
      tick();
      pc_src_ex = 1'b1; branch_target_ex = 32'h300;
      tick();
      pc_src_ex = 1'b0; stall_if = 1'b0;
      checks++; if (valid_id !== 1'b0 || INSTRUCTION_ID !== NOP) begin failures++; $display("FAIL hold_drop got=%b/%h exp=0/%h", valid_id, INSTRUCTION_ID, NOP); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin failures++; $display("FAIL hold_target got=%b/%h exp=1/300", bus.imem_req, bus.imem_addr); end
      fetch_word(32'h300, 32'h6000_0008, 1'b1);
   endtask

   task automatic test_wrap();
      pc_src_ex = 1'b1; branch_target_ex = 32'hFFFF_FFFE;
      tick();
      pc_src_ex = 1'b0;
      checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_align got=%h exp=fffffffc", bus.imem_addr); end
      fetch_word(32'hFFFF_FFFC, 32'h7000_0009, 1'b1);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_reset_mid();
      wait_req();
      addr_q.push_back(32'h0);
      bus.imem_gnt = 1'b1;
      tick();
      bus.imem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0 || valid_id !== 1'b0 || INSTRUCTION_ID !== NOP || PC_ID !== 32'h0) begin
         failures++; $display("FAIL mid_rst got=%b/%b/%h/%h exp=0/0/%h/0", bus.imem_req, valid_id, INSTRUCTION_ID, PC_ID, NOP);
      end
      tick();
      rst_n = 1'b1;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
      tick();
      bus.imem_rvalid = 1'b0;
      checks++; if (valid_id !== 1'b0) begin failures++; $display("FAIL mid_stray got=%b exp=0", valid_id); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mid_first got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
      fetch_word(32'h0, 32'h8000_000A, 1'b1);
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_reset_mid();
      checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL addr_q_left got=%0d exp=0", addr_q.size()); end
      checks++; if (id_q.size() != 0) begin failures++; $display("FAIL id_q_left got=%0d exp=0", id_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
